// File: rtl/gpio_port_ctrl_pkg.sv
// Shared constants for the GPIO port controller: register indices and parameter limits.
package gpio_port_ctrl_pkg;

  localparam int GPIO_MAX_WIDTH      = 32;
  localparam int GPIO_MAX_FILTER_LEN = 15;
  localparam int GPIO_CNT_W          = $clog2(GPIO_MAX_FILTER_LEN + 1);

  localparam logic [2:0] GPIO_DIR     = 3'd0;
  localparam logic [2:0] GPIO_OUT     = 3'd1;
  localparam logic [2:0] GPIO_IN      = 3'd2;
  localparam logic [2:0] GPIO_RISE_EN = 3'd3;
  localparam logic [2:0] GPIO_FALL_EN = 3'd4;
  localparam logic [2:0] GPIO_PEND    = 3'd5;
  localparam logic [2:0] GPIO_OUT_SET = 3'd6;
  localparam logic [2:0] GPIO_OUT_CLR = 3'd7;

endpackage

// File: rtl/gpio_in_filter.sv
// One pin's input path: 2-FF synchroniser, stability filter and one-cycle edge pulses.
module gpio_in_filter
  import gpio_port_ctrl_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic filt,
  output logic rise,
  output logic fall
);

  localparam logic [GPIO_CNT_W-1:0] LAST = GPIO_CNT_W'(FILTER_LEN - 1);

  logic                  meta;
  logic                  sync;
  logic [GPIO_CNT_W-1:0] cnt;

  // A change in sync while it differs from filt can only be a return to filt, so equality covers it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      cnt  <= '0;
      filt <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= pad;
      sync <= meta;
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync == filt) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt  <= '0;
        filt <= sync;
        rise <= sync;
        fall <= ~sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_port_ctrl.sv
// Register-mapped bidirectional GPIO controller with filtered inputs and edge interrupts.
module gpio_port_ctrl
  import gpio_port_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FILTER_LEN = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             bus_req_i,
  input  logic             bus_we_i,
  input  logic [2:0]       bus_addr_i,
  input  logic [31:0]      bus_wdata_i,
  output logic [31:0]      bus_rdata_o,
  output logic             bus_ack_o,
  output logic [WIDTH-1:0] pad_t_o,
  output logic [WIDTH-1:0] pad_i_o,
  input  logic [WIDTH-1:0] pad_o_i,
  output logic             irq_o
);

  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] in_filt;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] hw_set;
  logic [GPIO_MAX_WIDTH-1:0] rd_word;
  logic             wr;
  logic             unused_wdata;

  assign wdata        = bus_wdata_i[WIDTH-1:0];
  assign unused_wdata = ^bus_wdata_i;
  assign wr           = bus_req_i & bus_we_i;

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    gpio_in_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk   (clk_i),
      .rst_n (rstn_i),
      .pad   (pad_o_i[g]),
      .filt  (in_filt[g]),
      .rise  (rise[g]),
      .fall  (fall[g])
    );
  end

  always_comb begin
    rd_word = '0;
    case (bus_addr_i)
      GPIO_DIR:     rd_word[WIDTH-1:0] = dir;
      GPIO_OUT:     rd_word[WIDTH-1:0] = out_reg;
      GPIO_IN:      rd_word[WIDTH-1:0] = in_filt;
      GPIO_RISE_EN: rd_word[WIDTH-1:0] = rise_en;
      GPIO_FALL_EN: rd_word[WIDTH-1:0] = fall_en;
      GPIO_PEND:    rd_word[WIDTH-1:0] = pend;
      default:      rd_word = '0;
    endcase
  end

  assign w1c    = (wr && bus_addr_i == GPIO_PEND) ? wdata : '0;
  assign hw_set = (rise & rise_en) | (fall & fall_en);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dir     <= '0;
      out_reg <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else if (wr) begin
      case (bus_addr_i)
        GPIO_DIR:     dir     <= wdata;
        GPIO_OUT:     out_reg <= wdata;
        GPIO_RISE_EN: rise_en <= wdata;
        GPIO_FALL_EN: fall_en <= wdata;
        GPIO_OUT_SET: out_reg <= out_reg | wdata;
        GPIO_OUT_CLR: out_reg <= out_reg & ~wdata;
        default:      ;
      endcase
    end
  end

  // Hardware set is ORed after the clear so a colliding edge is never lost.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend        <= '0;
      irq_o       <= 1'b0;
      bus_ack_o   <= 1'b0;
      bus_rdata_o <= '0;
    end else begin
      pend        <= (pend & ~w1c) | hw_set;
      irq_o       <= |pend;
      bus_ack_o   <= bus_req_i;
      bus_rdata_o <= bus_req_i ? rd_word : '0;
    end
  end

  assign pad_t_o = ~dir;
  assign pad_i_o = out_reg;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Scoreboard bench for gpio_port_ctrl: random and directed bus/pad traffic against a window-based model.
module tb_gpio_port_ctrl;

  localparam int WIDTH      = 8;
  localparam int FILTER_LEN = 4;
  localparam logic [31:0] MASK = 32'h0000_00FF;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req;
  logic             we;
  logic [2:0]       addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             ack;
  logic [WIDTH-1:0] pad_t;
  logic [WIDTH-1:0] pad_i;
  logic [WIDTH-1:0] pad_o;
  logic             irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  // Model state as it stands after the most recent clock edge.
  logic [31:0]      m_dir, m_out, m_ren, m_fen, m_pend, m_filt, m_filt_prev;
  logic             m_irq;
  logic [WIDTH-1:0] hist[$];

  gpio_port_ctrl #(.WIDTH(WIDTH), .FILTER_LEN(FILTER_LEN)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .bus_req_i   (req),
    .bus_we_i    (we),
    .bus_addr_i  (addr),
    .bus_wdata_i (wdata),
    .bus_rdata_o (rdata),
    .bus_ack_o   (ack),
    .pad_t_o     (pad_t),
    .pad_i_o     (pad_i),
    .pad_o_i     (pad_o),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dir = 0; m_out = 0; m_ren = 0; m_fen = 0; m_pend = 0;
    m_filt = 0; m_filt_prev = 0; m_irq = 0;
    hist.delete();
    for (int i = 0; i < FILTER_LEN + 2; i++) hist.push_back('0);
    exp_q.delete();
  endtask

  function automatic logic [31:0] read_model(input logic [2:0] a);
    case (a)
      3'd0:    return m_dir;
      3'd1:    return m_out;
      3'd2:    return m_filt;
      3'd3:    return m_ren;
      3'd4:    return m_fen;
      3'd5:    return m_pend;
      default: return 32'h0;
    endcase
  endfunction

  // Filter rule: a pin's filtered value flips once its synchronised sample (pad two edges back)
  // has held the opposite value for FILTER_LEN consecutive edges.
  task automatic model_step();
    logic [31:0] set_bits, clr_bits, n_filt, w;
    logic        stable;
    w = wdata & MASK;
    if (req) exp_q.push_back('{!we, read_model(addr)});
    set_bits = ((m_filt & ~m_filt_prev & m_ren) | (~m_filt & m_filt_prev & m_fen)) & MASK;
    clr_bits = (req && we && addr == 3'd5) ? w : 32'h0;
    m_irq  = (m_pend != 0);
    m_pend = (m_pend & ~clr_bits) | set_bits;
    if (req && we) begin
      case (addr)
        3'd0: m_dir = w;
        3'd1: m_out = w;
        3'd3: m_ren = w;
        3'd4: m_fen = w;
        3'd6: m_out = m_out | w;
        3'd7: m_out = m_out & ~w;
        default: ;
      endcase
    end
    hist.push_back(pad_o);
    void'(hist.pop_front());
    n_filt = m_filt;
    for (int i = 0; i < WIDTH; i++) begin
      stable = 1'b1;
      for (int j = 1; j < FILTER_LEN; j++) if (hist[j][i] != hist[0][i]) stable = 1'b0;
      if (stable && hist[0][i] != m_filt[i]) n_filt[i] = hist[0][i];
    end
    m_filt_prev = m_filt;
    m_filt      = n_filt;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  task automatic check_output();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ack", {31'b0, ack}, 32'h1);
      if (e.is_read) check("rdata", rdata, e.data);
    end else begin
      check("stray_ack", {31'b0, ack}, 32'h0);
      check("idle_rdata", rdata, 32'h0);
    end
    check("pad_t", {24'b0, pad_t}, ~m_dir & MASK);
    check("pad_i", {24'b0, pad_i}, m_out & MASK);
    check("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check_output();
    end
  end

  task automatic apply_stimulus(input logic w, input logic [2:0] a, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int found;
    rstn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; pad_o = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    apply_stimulus(1'b0, 3'd2, 32'h0);
    idle(2);

    apply_stimulus(1'b1, 3'd0, 32'h0000_000F);
    apply_stimulus(1'b1, 3'd1, 32'h0000_00A5);
    idle(1);
    apply_stimulus(1'b1, 3'd6, 32'h0000_0010);
    apply_stimulus(1'b1, 3'd7, 32'h0000_0005);
    apply_stimulus(1'b0, 3'd1, 32'h0);
    apply_stimulus(1'b0, 3'd0, 32'h0);
    idle(2);

    // Back-to-back IN reads expose the exact filter latency and the dropped short pulse.
    pad_o[0] = 1'b1;
    repeat (8) apply_stimulus(1'b0, 3'd2, 32'h0);
    pad_o[1] = 1'b1;
    repeat (3) apply_stimulus(1'b0, 3'd2, 32'h0);
    pad_o[1] = 1'b0;
    repeat (8) apply_stimulus(1'b0, 3'd2, 32'h0);

    pad_o[0] = 1'b0;
    idle(8);
    apply_stimulus(1'b1, 3'd3, 32'h1);
    pad_o[0] = 1'b1;
    repeat (10) apply_stimulus(1'b0, 3'd5, 32'h0);
    apply_stimulus(1'b1, 3'd5, 32'h1);
    repeat (3) apply_stimulus(1'b0, 3'd5, 32'h0);

    // Land a W1C of PEND[1] on the edge where the bit1 fall pulse is live.
    apply_stimulus(1'b1, 3'd4, 32'h2);
    pad_o[1] = 1'b1;
    idle(8);
    pad_o[1] = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      if (m_filt_prev[1] && !m_filt[1]) found = 1;
      else idle(1);
    end
    check("collision_wait", found, 32'h1);
    apply_stimulus(1'b1, 3'd5, 32'h2);
    repeat (3) apply_stimulus(1'b0, 3'd5, 32'h0);
    apply_stimulus(1'b1, 3'd5, 32'hFFFF_FFFF);
    idle(2);

    apply_stimulus(1'b1, 3'd0, 32'hFFFF_FFFF);
    apply_stimulus(1'b0, 3'd0, 32'h0);
    apply_stimulus(1'b0, 3'd6, 32'h0);
    apply_stimulus(1'b0, 3'd7, 32'h0);

    req = 1'b1; we = 1'b0; addr = 3'd0;
    #2 rstn = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(3);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0) pad_o = 8'($urandom);
      if ($urandom_range(0, 2) != 0)
        apply_stimulus(1'($urandom), 3'($urandom), $urandom);
      else
        idle(1);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
